// File: rtl/v850_mem_pkg.sv
// Shared types for the memory-port arbiter: FSM states, transaction owner and port widths.
package v850_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int MEM_DATA_W = 64;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

endpackage

// File: rtl/mem_arb_select.sv
// Winner choice for the shared memory port: fixed LS-over-IF priority, optionally
// relaxed by a starvation guard when ARB_STARVE_GUARD_EN is defined.
module mem_arb_select
    import v850_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_req_eff,
    input  logic ls_req,
    input  logic if_granted,
    input  logic ls_granted,
    output logic pick_ls
);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    // Counts back-to-back LS wins while IF keeps asking; any IF win or IF backing off restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n || !if_req || if_granted) begin
            starve_cnt <= '0;
        end else if (ls_granted && starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign pick_ls = ls_req && !(if_req_eff && starve_cnt == CNT_W'(STARVE_MAX));
`else
    logic unused_guard;
    assign unused_guard = ^{clk, rst_n, if_req, if_req_eff, if_granted, ls_granted};

    assign pick_ls = ls_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS), one transaction
// at a time, with IF flush support. Optional starvation guard: ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import v850_mem_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,

    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_be,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  busy
);

    arb_state_t state;
    owner_t     owner;
    logic       drop;

    logic if_req_eff;
    logic pick_ls;
    logic gnt_now;
    logic rv_now;
    logic if_grant_raw;
    logic ls_grant_raw;

    // A flush in the arbitration cycle cancels that cycle's fetch request.
    assign if_req_eff   = if_req && !if_flush;

    assign gnt_now      = (state == REQ) && mem_gnt;
    assign rv_now       = (state == WAIT) && mem_rvalid;
    assign if_grant_raw = gnt_now && (owner == OWN_IF);
    assign ls_grant_raw = gnt_now && (owner == OWN_LS);

    // A dropped (flushed) fetch still completes on the memory side but is hidden from IF.
    assign if_gnt    = if_grant_raw && !drop && !if_flush;
    assign ls_gnt    = ls_grant_raw;
    assign if_rvalid = rv_now && (owner == OWN_IF) && !drop && !if_flush;
    assign ls_rvalid = rv_now && (owner == OWN_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;
    assign busy      = (state != IDLE);

    mem_arb_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_select (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_req_eff (if_req_eff),
        .ls_req     (ls_req),
        .if_granted (if_grant_raw),
        .ls_granted (ls_grant_raw),
        .pick_ls    (pick_ls)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            drop      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ls_req || if_req_eff) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                        drop    <= 1'b0;
                        if (pick_ls) begin
                            owner     <= OWN_LS;
                            mem_we    <= ls_we;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            mem_be    <= ls_be;
                        end else begin
                            owner     <= OWN_IF;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                        end
                    end
                end
                REQ: begin
                    if (owner == OWN_IF && if_flush) begin
                        drop <= 1'b1;
                    end
                    // mem_req is never withdrawn before the memory accepts it.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state <= IDLE;
                            drop  <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (owner == OWN_IF && if_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    drop    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized request pairs
// checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 25;
    localparam int DATA_W     = 64;
    localparam int BE_W       = DATA_W / 8;
    localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam int LS_RUN_LIMIT  = 1000;
    localparam int EXP_LS_BEFORE = STARVE_MAX;
`else
    localparam int LS_RUN_LIMIT  = 10;
    localparam int EXP_LS_BEFORE = 10;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req, if_flush, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata, ls_rdata;
    logic [BE_W-1:0]   ls_be;
    logic              mem_req, mem_we, mem_gnt, mem_rvalid, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [BE_W-1:0]   mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step(); step(); #2;
        n_tests++;
        if ({mem_req, mem_we, busy, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {mem_req, mem_we, busy, if_gnt, ls_gnt, if_rvalid, ls_rvalid});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, mem_be} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: addr %h wdata %h be %h want all 0", mem_addr, mem_wdata, mem_be);
        end
        step(); rst_n = 1'b1;
    endtask

    task automatic test_if_read();
        logic [DATA_W-1:0] d = 64'h1122334455667788;
        step(); if_req = 1'b1; if_addr = 25'h10; #2;
        n_tests++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL if_read_req_early: got %b want 0", mem_req); end
        step(); mem_gnt = 1'b1; #2;
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 25'h10, 8'hFF}) begin
            n_fail++;
            $display("FAIL if_read_issue: req %b we %b addr %h be %h want 1 0 010 ff", mem_req, mem_we, mem_addr, mem_be);
        end
        n_tests++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin n_fail++; $display("FAIL if_read_gnt: got %b want 10", {if_gnt, ls_gnt}); end
        step(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d; #2;
        n_tests++;
        if ({mem_req, if_rvalid, ls_rvalid, if_rdata} !== {1'b0, 1'b1, 1'b0, d}) begin
            n_fail++;
            $display("FAIL if_read_rvalid: req %b if_rv %b ls_rv %b data %h want 0 1 0 %h",
                     mem_req, if_rvalid, ls_rvalid, if_rdata, d);
        end
        step(); mem_rvalid = 1'b0; #2;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL if_read_idle: busy %b want 0", busy); end
    endtask

    task automatic test_priority();
        logic [DATA_W-1:0] d = {$urandom, $urandom};
        step(); if_req = 1'b1; if_addr = 25'h10; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 25'h20; #2;
        step(); mem_gnt = 1'b1; #2;
        n_tests++;
        if ({mem_addr, ls_gnt, if_gnt} !== {25'h20, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_ls_first: addr %h ls_gnt %b if_gnt %b want 020 1 0", mem_addr, ls_gnt, if_gnt);
        end
        step(); ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d; #2;
        n_tests++;
        if ({ls_rvalid, if_rvalid, ls_rdata} !== {1'b1, 1'b0, d}) begin
            n_fail++;
            $display("FAIL prio_ls_rvalid: ls_rv %b if_rv %b data %h want 1 0 %h", ls_rvalid, if_rvalid, ls_rdata, d);
        end
        step(); mem_rvalid = 1'b0; #2;
        n_tests++;
        if ({mem_req, busy} !== 2'b00) begin n_fail++; $display("FAIL prio_bubble: req/busy %b want 00", {mem_req, busy}); end
        step(); mem_gnt = 1'b1; #2;
        n_tests++;
        if ({mem_req, mem_addr, if_gnt} !== {1'b1, 25'h10, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_if_second: req %b addr %h if_gnt %b want 1 010 1", mem_req, mem_addr, if_gnt);
        end
        step(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = ~d; #2;
        n_tests++;
        if ({if_rvalid, if_rdata} !== {1'b1, ~d}) begin
            n_fail++;
            $display("FAIL prio_if_rvalid: rv %b data %h want 1 %h", if_rvalid, if_rdata, ~d);
        end
        step(); mem_rvalid = 1'b0;
    endtask

    task automatic test_ls_write();
        logic [DATA_W-1:0] wd = {$urandom, $urandom};
        step(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 25'h30; ls_wdata = wd; ls_be = 8'h0F; #2;
        step(); mem_gnt = 1'b1; mem_rvalid = 1'b1; #2;
        n_tests++;
        if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 25'h30, wd, 8'h0F}) begin
            n_fail++;
            $display("FAIL ls_write_payload: we %b addr %h wdata %h be %h want 1 030 %h 0f",
                     mem_we, mem_addr, mem_wdata, mem_be, wd);
        end
        n_tests++;
        if ({ls_gnt, ls_rvalid, if_gnt} !== 3'b100) begin
            n_fail++;
            $display("FAIL ls_write_gnt: ls_gnt/ls_rv/if_gnt %b want 100", {ls_gnt, ls_rvalid, if_gnt});
        end
        step(); ls_req = 1'b0; ls_we = 1'b0; mem_gnt = 1'b0; #2;
        n_tests++;
        if ({busy, mem_req, ls_rvalid, if_rvalid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL ls_write_done: busy/req/ls_rv/if_rv %b want 0000", {busy, mem_req, ls_rvalid, if_rvalid});
        end
        step(); mem_rvalid = 1'b0;
    endtask

    task automatic test_flush();
        // Flush while waiting for read data.
        step(); if_req = 1'b1; if_addr = 25'h40; #2;
        step(); mem_gnt = 1'b1; #2;
        step(); if_req = 1'b0; mem_gnt = 1'b0; if_flush = 1'b1; #2;
        step(); if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD; #2;
        n_tests++;
        if ({if_rvalid, ls_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_wait_rvalid: if/ls rvalid %b want 00", {if_rvalid, ls_rvalid});
        end
        step(); mem_rvalid = 1'b0; #2;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_wait_idle: busy %b want 0", busy); end
        // Flush before the memory grant: request must stay up, grant and data hidden.
        step(); if_req = 1'b1; if_addr = 25'h44; #2;
        step(); if_flush = 1'b1; #2;
        step(); if_flush = 1'b0; if_req = 1'b0; mem_gnt = 1'b1; #2;
        n_tests++;
        if ({mem_req, if_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_req_gnt: mem_req/if_gnt %b want 10", {mem_req, if_gnt});
        end
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #2;
        n_tests++;
        if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_req_rvalid: got %b want 0", if_rvalid); end
        step(); mem_rvalid = 1'b0; if_req = 1'b1; if_flush = 1'b1; #2;
        step(); if_req = 1'b0; if_flush = 1'b0; #2;
        n_tests++;
        if ({mem_req, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_idle_ignore: mem_req/busy %b want 00", {mem_req, busy});
        end
    endtask

    task automatic test_starve();
        int ls_cnt = 0;
        int if_at  = -1;
        step(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 25'h50; ls_be = '1;
        if_req = 1'b1; if_addr = 25'h60; #2;
        for (int c = 0; c < 80 && if_at < 0; c++) begin
            step();
            mem_gnt = mem_req;
            if (ls_cnt >= LS_RUN_LIMIT) ls_req = 1'b0;
            #2;
            if (ls_gnt) ls_cnt++;
            if (if_gnt) if_at = ls_cnt;
        end
        n_tests++;
        if (if_at !== EXP_LS_BEFORE) begin
            n_fail++;
            $display("FAIL starve_ls_grants_before_if: got %0d want %0d", if_at, EXP_LS_BEFORE);
        end
        step(); mem_gnt = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5A5A; #2;
        n_tests++;
        if ({if_rvalid, if_rdata} !== {1'b1, 64'h5A5A}) begin
            n_fail++;
            $display("FAIL starve_if_rvalid: rv %b data %h want 1 5a5a", if_rvalid, if_rdata);
        end
        step(); mem_rvalid = 1'b0; #2;
    endtask

    task automatic test_reset_mid();
        step(); if_req = 1'b1; if_addr = 25'h70; #2;
        step(); mem_gnt = 1'b1; #2;
        step(); mem_gnt = 1'b0; if_req = 1'b0; rst_n = 1'b0; #2;
        step(); rst_n = 1'b1; #2;
        n_tests++;
        if ({mem_req, mem_we, busy, mem_addr, mem_be, if_rvalid, ls_rvalid} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: req %b busy %b addr %h be %h want all 0", mem_req, busy, mem_addr, mem_be);
        end
        step(); mem_rvalid = 1'b1; mem_rdata = 64'h77; #2;
        n_tests++;
        if ({if_rvalid, ls_rvalid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_stale_rvalid: if/ls rv, busy %b want 000", {if_rvalid, ls_rvalid, busy});
        end
        step(); mem_rvalid = 1'b0;
    endtask

    // Each round raises a random IF and/or LS request while the port is idle; the model expects
    // LS to be served first, each transaction to carry its requester's payload, and one idle
    // cycle between transactions.
    task automatic test_random();
        bit                has_if, has_ls, is_ls, exp_we;
        logic [ADDR_W-1:0] ia, la, exp_addr;
        logic [DATA_W-1:0] lwd, exp_wdata, rd;
        logic [BE_W-1:0]   lbe, exp_be;
        bit                order[$];
        int                gw, rw;
        for (int it = 0; it < 30; it++) begin
            has_if = 1'($urandom); has_ls = 1'($urandom);
            if (!has_if && !has_ls) has_ls = 1'b1;
            ia = ADDR_W'($urandom); la = ADDR_W'($urandom);
            lwd = {$urandom, $urandom}; lbe = BE_W'($urandom);
            order.delete();
            if (has_ls) order.push_back(1'b1);
            if (has_if) order.push_back(1'b0);
            step();
            if_req = has_if; if_addr = ia;
            ls_req = has_ls; ls_we = 1'($urandom); ls_addr = la; ls_wdata = lwd; ls_be = lbe;
            #2;
            while (order.size() > 0) begin
                is_ls     = order.pop_front();
                exp_we    = is_ls ? ls_we : 1'b0;
                exp_addr  = is_ls ? la : ia;
                exp_wdata = is_ls ? lwd : '0;
                exp_be    = is_ls ? lbe : '1;
                gw = $urandom_range(0, 2);
                for (int w = 0; w <= gw; w++) begin
                    step(); mem_gnt = (w == gw); #2;
                    n_tests++;
                    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, exp_we, exp_addr, exp_wdata, exp_be}) begin
                        n_fail++;
                        $display("FAIL rand_payload it%0d: req %b we %b addr %h wdata %h be %h want 1 %b %h %h %h",
                                 it, mem_req, mem_we, mem_addr, mem_wdata, mem_be, exp_we, exp_addr, exp_wdata, exp_be);
                    end
                    n_tests++;
                    if ({ls_gnt, if_gnt} !== ((w == gw) ? {is_ls, !is_ls} : 2'b00)) begin
                        n_fail++;
                        $display("FAIL rand_gnt it%0d: ls/if gnt %b want %b", it, {ls_gnt, if_gnt},
                                 (w == gw) ? {is_ls, !is_ls} : 2'b00);
                    end
                end
                step(); mem_gnt = 1'b0;
                if (is_ls) ls_req = 1'b0; else if_req = 1'b0;
                if (!exp_we) begin
                    rw = $urandom_range(0, 2);
                    for (int w = 0; w <= rw; w++) begin
                        if (w > 0) step();
                        rd = {$urandom, $urandom};
                        mem_rvalid = (w == rw); mem_rdata = rd; #2;
                        n_tests++;
                        if ({ls_rvalid, if_rvalid} !== ((w == rw) ? {is_ls, !is_ls} : 2'b00) ||
                            ((w == rw) && ((is_ls ? ls_rdata : if_rdata) !== rd))) begin
                            n_fail++;
                            $display("FAIL rand_rvalid it%0d: ls/if rv %b ls_rdata %h if_rdata %h want owner %0d data %h",
                                     it, {ls_rvalid, if_rvalid}, ls_rdata, if_rdata, is_ls, rd);
                        end
                    end
                    step(); mem_rvalid = 1'b0;
                end
                #2;
                n_tests++;
                if ({busy, mem_req} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rand_bubble it%0d: busy/req %b want 00", it, {busy, mem_req});
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_if_read();
        test_priority();
        test_ls_write();
        test_flush();
        test_starve();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule
